// File: rtl/tlb_pkg.sv
// tlb_pkg: entry field layout helpers and shared constants for the TLB
package tlb_pkg;
  localparam int VPN2_W = 19;
  localparam logic [1:0] SEG_UNMAPPED = 2'b10;
  localparam logic [31:0] PROBE_MISS = 32'h8000_0000;
  function automatic int entry_w(input int pfn_w, input int asid_w);
    return VPN2_W + asid_w + 1 + 2 * (pfn_w + 2);
  endfunction
  function automatic int off_d1();
    return 1;
  endfunction
  function automatic int off_pfn1();
    return 2;
  endfunction
  function automatic int off_v0(input int pfn_w);
    return pfn_w + 2;
  endfunction
  function automatic int off_d0(input int pfn_w);
    return pfn_w + 3;
  endfunction
  function automatic int off_pfn0(input int pfn_w);
    return pfn_w + 4;
  endfunction
  function automatic int off_g(input int pfn_w);
    return 2 * pfn_w + 4;
  endfunction
  function automatic int off_asid(input int pfn_w);
    return 2 * pfn_w + 5;
  endfunction
  function automatic int off_vpn2(input int pfn_w, input int asid_w);
    return 2 * pfn_w + asid_w + 5;
  endfunction
endpackage

// File: rtl/tlb_match_port.sv
// tlb_match_port: combinational fully associative lookup of one virtual address
module tlb_match_port import tlb_pkg::*; #(
  parameter int NUM_ENTRY = 16,
  parameter int PFN_W = 20,
  parameter int ASID_W = 8,
  localparam int IDX_W = $clog2(NUM_ENTRY),
  localparam int ENTRY_W = entry_w(PFN_W, ASID_W),
  localparam int PA_W = PFN_W + 12
) (
  input  logic [NUM_ENTRY-1:0][ENTRY_W-1:0] entries,
  input  logic [31:0]                       vaddr,
  input  logic [ASID_W-1:0]                 asid,
  input  logic                              store,
  output logic                              hit,
  output logic [IDX_W-1:0]                  idx,
  output logic [PA_W-1:0]                   paddr,
  output logic                              miss,
  output logic                              invalid,
  output logic                              modified
);
  localparam int O_VPN2 = off_vpn2(PFN_W, ASID_W);
  localparam int O_ASID = off_asid(PFN_W);
  localparam int O_G = off_g(PFN_W);
  localparam int O_PFN0 = off_pfn0(PFN_W);
  localparam int O_D0 = off_d0(PFN_W);
  localparam int O_V0 = off_v0(PFN_W);
  localparam int O_PFN1 = off_pfn1();
  localparam int O_D1 = off_d1();
  logic [ENTRY_W-1:0] sel;
  logic [PFN_W-1:0] pfn;
  logic [31:0] direct;
  logic odd, v, d, unmapped;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--)
      if (entries[i][O_VPN2 +: VPN2_W] == vaddr[31:13] &&
          (entries[i][O_G] || entries[i][O_ASID +: ASID_W] == asid)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
  end
  assign sel = entries[idx];
  assign odd = vaddr[12];
  assign pfn = odd ? sel[O_PFN1 +: PFN_W] : sel[O_PFN0 +: PFN_W];
  assign v = odd ? sel[0] : sel[O_V0];
  assign d = odd ? sel[O_D1] : sel[O_D0];
  assign unmapped = vaddr[31:30] == SEG_UNMAPPED;
  assign direct = {3'b000, vaddr[28:0]};
  assign miss = !unmapped && !hit;
  assign invalid = !unmapped && hit && !v;
  assign modified = !unmapped && hit && v && store && !d;
  assign paddr = unmapped ? PA_W'(direct) : (miss || invalid || modified) ? '0 : {pfn, vaddr[11:0]};
endmodule

// File: rtl/tlb_mmu_param.sv
// tlb_mmu_param: multi-channel fully associative MIPS32 TLB with CP0 write/probe/read and Random
module tlb_mmu_param import tlb_pkg::*; #(
  parameter int NUM_ENTRY = 16,
  parameter int CH = 2,
  parameter int PFN_W = 20,
  parameter int ASID_W = 8,
  localparam int IDX_W = $clog2(NUM_ENTRY),
  localparam int ENTRY_W = entry_w(PFN_W, ASID_W),
  localparam int PA_W = PFN_W + 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ASID_W-1:0]    asid,
  input  logic [CH-1:0]        lk_req,
  input  logic [CH*32-1:0]     lk_vaddr,
  input  logic [CH-1:0]        lk_store,
  output logic [CH-1:0]        lk_done,
  output logic [CH*PA_W-1:0]   lk_paddr,
  output logic [CH-1:0]        lk_miss,
  output logic [CH-1:0]        lk_invalid,
  output logic [CH-1:0]        lk_modified,
  input  logic [ENTRY_W-1:0]   w_entry,
  input  logic [IDX_W-1:0]     w_index,
  input  logic [IDX_W-1:0]     wired,
  input  logic                 tlbwi,
  input  logic                 tlbwr,
  input  logic                 tlbp,
  input  logic                 tlbr,
  output logic [31:0]          tlbp_result,
  output logic [ENTRY_W-1:0]   tlbr_data,
  output logic                 op_done,
  output logic [IDX_W-1:0]     random
);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(NUM_ENTRY - 1);
  localparam int O_VPN2 = off_vpn2(PFN_W, ASID_W);
  logic [NUM_ENTRY-1:0][ENTRY_W-1:0] tlb;
  logic [IDX_W-1:0] wired_q;
  logic [CH-1:0] hit_c, miss_c, inv_c, mod_c;
  logic [CH-1:0][IDX_W-1:0] idx_c;
  logic [CH-1:0][PA_W-1:0] pa_c, paddr_q;
  logic p_hit, p_miss, p_inv, p_mod;
  logic [IDX_W-1:0] p_idx;
  logic [PA_W-1:0] p_pa;
  logic unused_ok;
  for (genvar g = 0; g < CH; g++) begin : g_ch
    tlb_match_port #(.NUM_ENTRY(NUM_ENTRY), .PFN_W(PFN_W), .ASID_W(ASID_W)) u_match (
      .entries(tlb), .vaddr(lk_vaddr[32*g +: 32]), .asid(asid), .store(lk_store[g]),
      .hit(hit_c[g]), .idx(idx_c[g]), .paddr(pa_c[g]),
      .miss(miss_c[g]), .invalid(inv_c[g]), .modified(mod_c[g])
    );
  end
  tlb_match_port #(.NUM_ENTRY(NUM_ENTRY), .PFN_W(PFN_W), .ASID_W(ASID_W)) u_probe (
    .entries(tlb), .vaddr({w_entry[O_VPN2 +: VPN2_W], 13'b0}), .asid(asid), .store(1'b0),
    .hit(p_hit), .idx(p_idx), .paddr(p_pa),
    .miss(p_miss), .invalid(p_inv), .modified(p_mod)
  );
  assign lk_paddr = paddr_q;
  assign unused_ok = ^{hit_c, idx_c, p_miss, p_inv, p_mod, p_pa};
  always_ff @(posedge clk) begin
    if (rst) begin
      tlb <= '0;
      random <= TOP;
      wired_q <= wired;
      lk_done <= '0;
      lk_miss <= '0;
      lk_invalid <= '0;
      lk_modified <= '0;
      paddr_q <= '0;
      op_done <= 1'b0;
      tlbp_result <= PROBE_MISS;
      tlbr_data <= '0;
    end else begin
      if (tlbwi) tlb[w_index] <= w_entry;
      else if (tlbwr) tlb[random] <= w_entry;
      random <= (wired != wired_q || random == wired) ? TOP : random - IDX_W'(1);
      wired_q <= wired;
      lk_done <= lk_req;
      lk_miss <= lk_req & miss_c;
      lk_invalid <= lk_req & inv_c;
      lk_modified <= lk_req & mod_c;
      for (int c = 0; c < CH; c++) paddr_q[c] <= lk_req[c] ? pa_c[c] : '0;
      op_done <= tlbp | tlbr;
      if (tlbp) tlbp_result <= p_hit ? 32'(p_idx) : PROBE_MISS;
      if (tlbr) tlbr_data <= tlb[w_index];
    end
  end
endmodule

// File: tb/tb_tlb_mmu_param.sv
// tb_tlb_mmu_param: table-driven, directed and randomized checks of tlb_mmu_param against a reference model
module tb_tlb_mmu_param;
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0] asid;
    logic g;
    logic [19:0] pfn0;
    logic d0;
    logic v0;
    logic [19:0] pfn1;
    logic d1;
    logic v1;
  } ent_t;
  typedef struct {
    int ch;
    logic [31:0] va;
    logic [7:0] as;
    logic st;
    logic [31:0] pa;
    logic mi;
    logic iv;
    logic mo;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] asid;
  logic [1:0] lk_req, lk_store, lk_done, lk_miss, lk_invalid, lk_modified;
  logic [63:0] lk_vaddr, lk_paddr;
  ent_t we;
  logic [71:0] w_entry, tlbr_data;
  logic [3:0] w_index, wired, random;
  logic tlbwi, tlbwr, tlbp, tlbr, op_done;
  logic [31:0] tlbp_result;
  int total = 0;
  int bad = 0;
  ent_t m_e [16];
  int m_rand;
  logic [3:0] m_wprev;
  logic [1:0] e_done, e_mi, e_iv, e_mo;
  logic [31:0] e_pa [2];
  logic e_op;
  logic [31:0] e_probe;
  logic [71:0] e_rd;
  vec_t vt [11];
  ent_t e3, e7, e13, old;
  int r;

  assign w_entry = we;
  always #5 clk = ~clk;

  tlb_mmu_param dut (
    .clk(clk), .rst(rst), .asid(asid), .lk_req(lk_req), .lk_vaddr(lk_vaddr), .lk_store(lk_store),
    .lk_done(lk_done), .lk_paddr(lk_paddr), .lk_miss(lk_miss), .lk_invalid(lk_invalid),
    .lk_modified(lk_modified), .w_entry(w_entry), .w_index(w_index), .wired(wired),
    .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbp(tlbp), .tlbr(tlbr), .tlbp_result(tlbp_result),
    .tlbr_data(tlbr_data), .op_done(op_done), .random(random)
  );

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic void ref_lookup(input logic [31:0] va, input logic [7:0] as, input logic st,
                                     output logic [31:0] pa, output logic mi, output logic iv, output logic mo);
    int h;
    logic v, d;
    logic [19:0] pfn;
    h = -1;
    pa = 32'h0;
    mi = 1'b0;
    iv = 1'b0;
    mo = 1'b0;
    if (va[31:30] == 2'b10) begin
      pa = {3'b000, va[28:0]};
      return;
    end
    for (int i = 0; i < 16 && h < 0; i++)
      if (m_e[i].vpn2 == va[31:13] && (m_e[i].g || m_e[i].asid == as)) h = i;
    if (h < 0) begin
      mi = 1'b1;
      return;
    end
    v = va[12] ? m_e[h].v1 : m_e[h].v0;
    d = va[12] ? m_e[h].d1 : m_e[h].d0;
    pfn = va[12] ? m_e[h].pfn1 : m_e[h].pfn0;
    if (!v) iv = 1'b1;
    else if (st && !d) mo = 1'b1;
    else pa = {pfn, va[11:0]};
  endfunction

  function automatic logic [31:0] ref_probe(input logic [18:0] vpn, input logic [7:0] as);
    for (int i = 0; i < 16; i++)
      if (m_e[i].vpn2 == vpn && (m_e[i].g || m_e[i].asid == as)) return 32'(i);
    return 32'h8000_0000;
  endfunction

  task automatic cycle();
    int wi;
    logic [31:0] pa;
    logic mi, iv, mo;
    for (int c = 0; c < 2; c++) begin
      ref_lookup(lk_vaddr[32*c +: 32], asid, lk_store[c], pa, mi, iv, mo);
      e_pa[c] = pa;
      e_mi[c] = mi;
      e_iv[c] = iv;
      e_mo[c] = mo;
    end
    e_done = lk_req;
    e_op = tlbp | tlbr;
    if (tlbp) e_probe = ref_probe(we.vpn2, asid);
    if (tlbr) e_rd = m_e[w_index];
    wi = tlbwi ? int'(w_index) : tlbwr ? m_rand : -1;
    @(posedge clk);
    if (rst) begin
      foreach (m_e[i]) m_e[i] = '0;
      m_rand = 15;
      e_done = 2'b00;
      e_op = 1'b0;
      e_probe = 32'h8000_0000;
      e_rd = '0;
    end else begin
      if (wi >= 0) m_e[wi] = we;
      m_rand = (wired != m_wprev || m_rand == int'(wired)) ? 15 : m_rand - 1;
    end
    m_wprev = wired;
    #1;
    chk("random", 72'(random), 72'(m_rand));
    chk("lk_done", 72'(lk_done), 72'(e_done));
    for (int c = 0; c < 2; c++)
      if (e_done[c]) begin
        chk($sformatf("paddr ch%0d", c), 72'(lk_paddr[32*c +: 32]), 72'(e_pa[c]));
        chk($sformatf("flags ch%0d", c), 72'({lk_miss[c], lk_invalid[c], lk_modified[c]}),
            72'({e_mi[c], e_iv[c], e_mo[c]}));
      end
    chk("op_done", 72'(op_done), 72'(e_op));
    chk("tlbp_result", 72'(tlbp_result), 72'(e_probe));
    chk("tlbr_data", tlbr_data, e_rd);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      lk_req = 2'b00;
      lk_store = 2'b00;
      lk_req[vt[i].ch] = 1'b1;
      lk_store[vt[i].ch] = vt[i].st;
      lk_vaddr[32*vt[i].ch +: 32] = vt[i].va;
      asid = vt[i].as;
      cycle();
      chk($sformatf("vec%0d done", i), 72'(lk_done[vt[i].ch]), 72'(1));
      chk($sformatf("vec%0d paddr", i), 72'(lk_paddr[32*vt[i].ch +: 32]), 72'(vt[i].pa));
      chk($sformatf("vec%0d flags", i),
          72'({lk_miss[vt[i].ch], lk_invalid[vt[i].ch], lk_modified[vt[i].ch]}),
          72'({vt[i].mi, vt[i].iv, vt[i].mo}));
    end
    lk_req = 2'b00;
  endtask

  function automatic logic [31:0] rand_va();
    int k;
    logic [18:0] vp;
    if ($urandom % 8 == 0) return $urandom;
    k = $urandom % 4;
    vp = k == 0 ? 19'h00200 : k == 1 ? 19'h00201 : k == 2 ? 19'h00400 : 19'h00777;
    return {vp, 13'($urandom)};
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    logic [31:0] va;
    e = 72'({$urandom, $urandom, $urandom});
    va = rand_va();
    e.vpn2 = va[31:13];
    e.asid = ($urandom % 2) ? 8'd5 : 8'd6;
    return e;
  endfunction

  initial begin
    rst = 1'b1;
    asid = '0;
    lk_req = '0;
    lk_vaddr = '0;
    lk_store = '0;
    we = '0;
    w_index = '0;
    wired = '0;
    tlbwi = 1'b0;
    tlbwr = 1'b0;
    tlbp = 1'b0;
    tlbr = 1'b0;
    e3 = '{19'h00200, 8'd5, 1'b0, 20'h01234, 1'b0, 1'b1, 20'h05678, 1'b0, 1'b0};
    e7 = '{19'h00200, 8'd5, 1'b1, 20'hAAAAA, 1'b1, 1'b1, 20'h00000, 1'b0, 1'b0};
    e13 = '{19'h00400, 8'd1, 1'b1, 20'h0BEEF, 1'b1, 1'b1, 20'h0CAFE, 1'b1, 1'b1};
    vt[0] = '{1, 32'h0040_0000, 8'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1, 32'h0040_0ABC, 8'd5, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{0, 32'h0040_0ABC, 8'd5, 1'b0, 32'h0123_4ABC, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1, 32'h0040_0ABC, 8'd6, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    vt[4] = '{0, 32'h0040_1000, 8'd5, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    vt[5] = '{0, 32'h0040_1234, 8'd5, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0};
    vt[6] = '{1, 32'hBFC0_0004, 8'd9, 1'b1, 32'h1FC0_0004, 1'b0, 1'b0, 1'b0};
    vt[7] = '{0, 32'h0123_4000, 8'd5, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    vt[8] = '{1, 32'h0040_0ABC, 8'd6, 1'b0, 32'h0123_4ABC, 1'b0, 1'b0, 1'b0};
    vt[9] = '{0, 32'h0040_0ABC, 8'd6, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1};
    vt[10] = '{1, 32'h0040_1FFF, 8'd9, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    cycle();
    cycle();
    chk("reset random", 72'(random), 72'(15));
    chk("reset lk_done", 72'(lk_done), 72'(0));
    chk("reset lk_paddr", 72'(lk_paddr), 72'(0));
    chk("reset tlbp_result", 72'(tlbp_result), 72'(32'h8000_0000));
    chk("reset tlbr_data", tlbr_data, 72'(0));
    rst = 1'b0;
    run_vecs(0, 1);
    we = e3;
    w_index = 4'd3;
    tlbwi = 1'b1;
    cycle();
    tlbwi = 1'b0;
    run_vecs(1, 8);
    e3.g = 1'b1;
    we = e3;
    tlbwi = 1'b1;
    cycle();
    we = e7;
    w_index = 4'd7;
    cycle();
    tlbwi = 1'b0;
    run_vecs(8, 11);
    lk_req = 2'b11;
    lk_store = 2'b11;
    lk_vaddr = {32'h8000_2000, 32'hA000_1000};
    cycle();
    lk_req = 2'b00;
    chk("kseg ch0 paddr", 72'(lk_paddr[31:0]), 72'(32'h0000_1000));
    chk("kseg ch1 paddr", 72'(lk_paddr[63:32]), 72'(32'h0000_2000));
    chk("kseg flags", 72'({lk_miss, lk_invalid, lk_modified}), 72'(0));
    wired = 4'd12;
    cycle();
    chk("rand seq0", 72'(random), 72'(15));
    cycle();
    chk("rand seq1", 72'(random), 72'(14));
    cycle();
    chk("rand seq2", 72'(random), 72'(13));
    we = e13;
    tlbwr = 1'b1;
    cycle();
    tlbwr = 1'b0;
    chk("rand seq3", 72'(random), 72'(12));
    w_index = 4'd13;
    tlbr = 1'b1;
    cycle();
    tlbr = 1'b0;
    chk("rand seq4", 72'(random), 72'(15));
    chk("tlbwr read op_done", 72'(op_done), 72'(1));
    chk("tlbwr read data", tlbr_data, 72'(e13));
    wired = 4'd15;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("wired top hold", 72'(random), 72'(15));
    end
    wired = 4'd0;
    cycle();
    we = e3;
    asid = 8'd6;
    tlbp = 1'b1;
    cycle();
    chk("probe hit", 72'(tlbp_result), 72'(3));
    we.vpn2 = 19'h12345;
    cycle();
    chk("probe absent", 72'(tlbp_result), 72'(32'h8000_0000));
    we = '{19'h00777, 8'd6, 1'b0, 20'h00777, 1'b1, 1'b1, 20'h0, 1'b0, 1'b0};
    w_index = 4'd5;
    tlbwi = 1'b1;
    cycle();
    tlbwi = 1'b0;
    chk("probe sees old", 72'(tlbp_result), 72'(32'h8000_0000));
    cycle();
    tlbp = 1'b0;
    chk("probe after write", 72'(tlbp_result), 72'(5));
    cycle();
    chk("probe hold op_done", 72'(op_done), 72'(0));
    chk("probe hold", 72'(tlbp_result), 72'(5));
    we = e3;
    w_index = 4'd3;
    tlbp = 1'b1;
    tlbr = 1'b1;
    cycle();
    tlbp = 1'b0;
    tlbr = 1'b0;
    chk("p+r probe", 72'(tlbp_result), 72'(3));
    chk("p+r read", tlbr_data, 72'(e3));
    r = m_rand;
    old = m_e[r];
    we = e13;
    w_index = 4'(r ^ 1);
    tlbwi = 1'b1;
    tlbwr = 1'b1;
    cycle();
    tlbwi = 1'b0;
    tlbwr = 1'b0;
    w_index = 4'(r);
    tlbr = 1'b1;
    cycle();
    tlbr = 1'b0;
    chk("wi beats wr", tlbr_data, 72'(old));
    lk_req = 2'b11;
    lk_vaddr = {32'h0040_0ABC, 32'h8000_0000};
    tlbp = 1'b1;
    rst = 1'b1;
    cycle();
    chk("rst drops done", 72'(lk_done), 72'(0));
    chk("rst drops op_done", 72'(op_done), 72'(0));
    rst = 1'b0;
    tlbp = 1'b0;
    lk_req = 2'b00;
    cycle();
    for (int n = 0; n < 400; n++) begin
      lk_req = 2'($urandom);
      lk_store = 2'($urandom);
      asid = ($urandom % 2) ? 8'd5 : 8'd6;
      lk_vaddr = {rand_va(), rand_va()};
      we = rand_ent();
      w_index = 4'($urandom);
      tlbwi = ($urandom % 6) == 0;
      tlbwr = ($urandom % 6) == 0;
      tlbp = ($urandom % 6) == 0;
      tlbr = ($urandom % 6) == 0;
      if ($urandom % 32 == 0) wired = 4'($urandom_range(0, 15));
      rst = ($urandom % 200) == 0;
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tlb_mmu_param.md
Name: tlb_mmu_param

Overview:
Parametrised, fully associative MIPS32-style TLB with NUM_ENTRY entries. It serves CH independent translation channels (default 2: ch0 instruction, ch1 data) with one-cycle registered results. It executes TLBWI, TLBWR, TLBP and TLBR for CP0 and maintains the Random register against Wired. It sits between the pipeline address stages and the memory interface and replaces the single-shot converter stub.

Parameters:
NUM_ENTRY, 16, number of TLB entries (power of 2, 4..64)
CH, 2, number of lookup channels
PFN_W, 20, physical frame number width (paddr width = PFN_W+12)
ASID_W, 8, address-space ID width
Derived localparams: IDX_W=$clog2(NUM_ENTRY); ENTRY_W=19+ASID_W+1+2*(PFN_W+2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
asid  in  ASID_W  current ASID (EntryHi.ASID)
lk_req  in  CH  per-channel lookup request
lk_vaddr  in  CH*32  per-channel virtual address, ch i at [32i+31:32i]
lk_store  in  CH  per-channel store access (dirty check)
lk_done  out  CH  result valid, one cycle after lk_req
lk_paddr  out  CH*(PFN_W+12)  translated address
lk_miss  out  CH  no matching entry (TLB refill)
lk_invalid  out  CH  matching entry has V=0
lk_modified  out  CH  store hit on page with D=0
w_entry  in  ENTRY_W  entry {VPN2,ASID,G,PFN0,D0,V0,PFN1,D1,V1}, MSB first
w_index  in  IDX_W  CP0 Index for TLBWI/TLBR
wired  in  IDX_W  CP0 Wired
tlbwi  in  1  write w_entry at w_index
tlbwr  in  1  write w_entry at random
tlbp  in  1  probe with {w_entry VPN2 field, asid}
tlbr  in  1  read entry at w_index
tlbp_result  out  32  bit31=1 no match; else IDX in low bits, others 0
tlbr_data  out  ENTRY_W  entry read by TLBR
op_done  out  1  pulse one cycle after tlbp or tlbr
random  out  IDX_W  current Random register

Behaviour:
- Reset (rst=1 at clk edge): all entries zeroed (V0=V1=G=0); random=NUM_ENTRY-1; lk_done, lk_miss, lk_invalid, lk_modified, op_done=0; lk_paddr=0; tlbp_result=32'h8000_0000; tlbr_data=0. Reset mid-operation discards pending results; no lk_done/op_done follows.
- Match: entry VPN2==vaddr[31:13] and (G or entry ASID==asid). vaddr[12] selects odd (PFN1/D1/V1) or even page. paddr={PFN,vaddr[11:0]}.
- Multiple matches: lowest index wins (deterministic).
- Unmapped: vaddr[31:30]==2'b10 (kseg0/kseg1) -> paddr=vaddr[PFN_W+11:0] with bits [31:29] zeroed; no flags.
- Latency: lk_req in cycle N -> lk_done plus all flags registered in cycle N+1. Channels are independent and fully pipelined: one request per channel per cycle. Flags are mutually exclusive, priority miss > invalid > modified. lk_paddr is 0 whenever any flag is set.
- Writes: take effect at the clk edge. A same-cycle lookup/probe/read sees old contents (read-before-write). tlbwi and tlbwr together: tlbwi wins, tlbwr ignored.
- Random: decrements every cycle. At random==wired, next value is NUM_ENTRY-1. A change in wired reloads NUM_ENTRY-1. wired==NUM_ENTRY-1 holds random at NUM_ENTRY-1. The value used by tlbwr is the value sampled in that same cycle.
- tlbp/tlbr: result registered, op_done pulses in the next cycle. Result outputs hold until the next op. tlbp and tlbr together: both execute.

Decomposition:
- Shared package tlb_pkg: entry field offsets/widths as localparam functions of PFN_W/ASID_W, unmapped-segment constant 2'b10, tlbp no-match constant 32'h8000_0000.
- Sub-module tlb_match_port: combinational matcher (entry array in, vaddr/asid/store in, hit index/paddr/flags out). Instantiated CH times plus once for tlbp.

Test Plan:
- Reset then lookup ch1 vaddr 32'h0040_0000 -> next cycle lk_done[1]=1, lk_miss[1]=1; random=15.
- tlbwi idx3 VPN2=19'h00200, ASID=5, PFN0=20'h01234, V0=1, D0=0; asid=5; store to 32'h0040_0ABC -> lk_modified=1. Load -> lk_paddr=32'h0123_4ABC.
- Same entry, asid=6, G=0 -> miss. Rewrite with G=1 -> hit. Odd-page lookup 32'h0040_1000 with V1=0 -> lk_invalid=1.
- wired=12: random sequence 15,14,13,12,15. tlbwr when random=13 -> tlbr idx13 returns written entry.
- tlbp for existing VPN2 -> tlbp_result=3. Absent VPN2 -> 32'h8000_0000. tlbwi and tlbp same cycle to same VPN2 -> probe misses (old contents).
- ch0 vaddr 32'hA000_1000 and ch1 vaddr 32'h8000_2000 same cycle -> paddr 32'h0000_1000 and 32'h0000_2000, no flags. Assert rst during a request -> no lk_done next cycle.
